// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer: streams one IX x IX input map from the frame buffer into the conv core and
// writes the core's output pixels to the output buffer. Drain timeout: CNN_FRAME_CTRL_TIMEOUT_EN.
module cnn_frame_ctrl #(
  parameter int unsigned I_F_BW = 8,
  parameter int unsigned CI     = 1,
  parameter int unsigned CO     = 3,
  parameter int unsigned O_F_BW = 20,
  parameter int unsigned IX     = 28,
  parameter int unsigned KX     = 5,
  parameter int unsigned N_OUT  = (IX - KX + 1) * (IX - KX + 1),
  parameter int unsigned RA_BW  = $clog2(IX * IX),
  parameter int unsigned WA_BW  = $clog2(N_OUT),
  parameter int unsigned TO_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_rd_en,
  output logic [RA_BW-1:0]       o_rd_addr,
  input  logic [CI*I_F_BW-1:0]   i_rd_data,
  output logic                   o_core_valid,
  output logic [CI*I_F_BW-1:0]   o_core_fmap,
  input  logic                   i_core_valid,
  input  logic [CO*O_F_BW-1:0]   i_core_fmap,
  output logic                   o_wr_en,
  output logic [WA_BW-1:0]       o_wr_addr,
  output logic [CO*O_F_BW-1:0]   o_wr_data
);

  localparam logic [RA_BW-1:0] RdLast  = RA_BW'(IX * IX - 1);
  localparam logic [RA_BW-1:0] RdTotal = RA_BW'(IX * IX);
  localparam logic [WA_BW-1:0] WrLast  = WA_BW'(N_OUT - 1);
  localparam logic [WA_BW-1:0] WrTotal = WA_BW'(N_OUT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic [RA_BW-1:0]      rd_cnt_q;
  logic [WA_BW-1:0]      wr_cnt_q;
  logic                  rd_en_q;
  logic                  core_valid_q;
  logic                  wr_en_q;
  logic [WA_BW-1:0]      wr_addr_q;
  logic [CO*O_F_BW-1:0]  wr_data_q;
  logic                  done_q;

  logic wr_take;
  logic wr_done_next;
  logic to_expired;

  // Outputs arriving after the last expected write are dropped.
  assign wr_take      = i_core_valid && (wr_cnt_q != WrTotal);
  assign wr_done_next = (wr_cnt_q == WrTotal) || (wr_take && (wr_cnt_q == WrLast));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      rd_en_q      <= 1'b0;
      core_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      core_valid_q <= rd_en_q;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q  <= StRun;
            rd_en_q  <= 1'b1;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
          end
        end
        StRun, StDrain: begin
          if (i_abort) begin
            // Kill the in-flight read as well as any pending write.
            state_q      <= StIdle;
            rd_en_q      <= 1'b0;
            core_valid_q <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
          end else begin
            if (wr_take) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_cnt_q;
              wr_data_q <= i_core_fmap;
              wr_cnt_q  <= wr_cnt_q + 1'b1;
            end
            if (state_q == StRun) begin
              if (rd_cnt_q != RdTotal) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
              end
              if (rd_cnt_q == RdLast) begin
                rd_en_q <= 1'b0;
                if (wr_done_next) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= StDrain;
                end
              end
            end else if (wr_done_next || to_expired) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef CNN_FRAME_CTRL_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TO_CYC + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TO_CYC - 1);

  logic [ToW-1:0] to_cnt_q;
  logic           err_q;

  // Fires on the TO_CYC-th consecutive quiet cycle counted from the last core output.
  assign to_expired = (state_q == StDrain) && !i_core_valid && (to_cnt_q == ToLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if ((state_q != StDrain) || i_core_valid) begin
      to_cnt_q <= '0;
    end else if (!to_expired) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((state_q == StIdle) && i_start) begin
      err_q <= 1'b0;
    end else if (to_expired && !i_abort) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign to_expired = 1'b0;
  assign o_err      = 1'b0;
`endif

  assign o_busy       = (state_q == StRun) || (state_q == StDrain);
  assign o_done       = done_q;
  assign o_rd_en      = rd_en_q;
  assign o_rd_addr    = rd_en_q ? rd_cnt_q : '0;
  assign o_core_valid = core_valid_q;
  assign o_core_fmap  = core_valid_q ? i_rd_data : '0;
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Bench for cnn_frame_ctrl: frame buffer and core models feed scoreboards of expected reads and
// writes; directed frames cover nominal, minimum, overflow, busy-start, abort, reset and timeout.
module tb_cnn_frame_ctrl;

  localparam int unsigned IX     = 28;
  localparam int unsigned KX     = 5;
  localparam int unsigned NPIX   = IX * IX;
  localparam int unsigned N_OUT  = (IX - KX + 1) * (IX - KX + 1);
  localparam int unsigned TO_CYC = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_rd_en;
  logic [9:0]  o_rd_addr;
  logic [7:0]  i_rd_data = 8'ha5;
  logic        o_core_valid;
  logic [7:0]  o_core_fmap;
  logic        i_core_valid = 1'b0;
  logic [59:0] i_core_fmap = '0;
  logic        o_wr_en;
  logic [9:0]  o_wr_addr;
  logic [59:0] o_wr_data;

  cnn_frame_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_core_valid (o_core_valid),
    .o_core_fmap  (o_core_fmap),
    .i_core_valid (i_core_valid),
    .i_core_fmap  (i_core_fmap),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [59:0] data;
  } wr_t;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] rd_q[$];
  wr_t        wr_q[$];
  int exp_rd = 0, exp_wr_idx = 0;
  int rd_seen = 0, wr_seen = 0, done_seen = 0;
  int cyc = 0, done_cyc = 0, last_valid_edge = 0;

  bit core_en = 1'b0;
  int core_wait = 0, core_budget = 0, core_gap = 0, core_sent = 0, core_tick = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Frame buffer: word at address k holds k[7:0], returned one cycle after the read.
  logic [7:0] rd_nxt = 8'ha5;
  always @(negedge clk) if (o_rd_en) rd_nxt = o_rd_addr[7:0];
  always @(posedge clk) begin
    #1;
    i_rd_data = rd_nxt;
  end

  // Core model: after core_wait cycles, emits up to core_budget outputs, skipping every
  // core_gap-th cycle; only outputs the controller should keep are scoreboarded.
  always @(posedge clk) begin
    logic [63:0] r;
    wr_t e;
    #1;
    i_core_valid = 1'b0;
    if (core_en) begin
      if (core_wait > 0) begin
        core_wait--;
      end else begin
        core_tick++;
        if (core_sent < core_budget && !(core_gap != 0 && core_tick % core_gap == 0)) begin
          r = {$urandom(), $urandom()};
          i_core_fmap  = r[59:0];
          i_core_valid = 1'b1;
          core_sent++;
          last_valid_edge = cyc + 1;
          if (exp_wr_idx < int'(N_OUT)) begin
            e.addr = 10'(exp_wr_idx);
            e.data = r[59:0];
            wr_q.push_back(e);
            exp_wr_idx++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    logic [7:0] f;
    if (o_done) done_seen++;
    if (o_rd_en) begin
      check("rd_addr", o_rd_addr, exp_rd);
      rd_q.push_back(8'(exp_rd));
      exp_rd++;
      rd_seen++;
    end
    if (o_core_valid) begin
      check("rd_pending", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) begin
        f = rd_q.pop_front();
        check("core_fmap", o_core_fmap, f);
      end
    end else begin
      check("fmap_gated", o_core_fmap, 0);
    end
    if (o_wr_en) begin
      wr_seen++;
      check("wr_pending", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_addr", o_wr_addr, e.addr);
        check("wr_data", o_wr_data, e.data);
      end
    end
  end

  task automatic start_frame(input int dly, input int budget, input int gap, input bit abort_too);
    @(posedge clk);
    #1;
    rd_q.delete();
    wr_q.delete();
    exp_rd = 0; exp_wr_idx = 0;
    rd_seen = 0; wr_seen = 0; done_seen = 0;
    core_wait = dly; core_budget = budget; core_gap = gap; core_sent = 0; core_tick = 0;
    i_start = 1'b1;
    i_abort = abort_too;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    core_en = 1'b1;
    check("first_rd_en", o_rd_en, 1);
    check("first_rd_addr", o_rd_addr, 0);
    check("err_clear", o_err, 0);
  endtask

  task automatic run_frame(input int dly, input int budget, input int gap, input bit poke,
                           input int exp_wr, input bit exp_err, input bit abort_too);
    int busy_low;
    bit got;
    bit poked;
    busy_low = 0; got = 1'b0; poked = 1'b0;
    start_frame(dly, budget, gap, abort_too);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (!o_busy) busy_low++;
      if (poke && !poked && o_busy && !o_rd_en) begin
        i_start = 1'b1;
        poked = 1'b1;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    check("done_seen", got, 1);
    check("busy_gap", busy_low, 0);
    check("busy_in_done", o_busy, 0);
    check("err", o_err, exp_err);
    core_en = 1'b0;
    repeat (4) @(negedge clk);
    check("done_count", done_seen, 1);
    check("rd_count", rd_seen, NPIX);
    check("wr_count", wr_seen, exp_wr);
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("idle_busy", o_busy, 0);
  endtask

  initial begin
    int c;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_rd_en", o_rd_en, 0);
    check("rst_rd_addr", o_rd_addr, 0);
    check("rst_core_valid", o_core_valid, 0);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    reset_n = 1'b1;

    // Nominal frame with writes stretching into DRAIN.
    run_frame(300, N_OUT, 7, 1'b0, N_OUT, 1'b0, 1'b0);
    // Minimum frame: all writes land during RUN, RUN goes straight to DONE.
    run_frame(0, N_OUT, 0, 1'b0, N_OUT, 1'b0, 1'b0);
    // Overflow: 4 surplus core outputs must be dropped.
    run_frame(250, N_OUT + 4, 0, 1'b0, N_OUT, 1'b0, 1'b0);
    // Start pulsed during DRAIN is ignored.
    run_frame(300, N_OUT, 5, 1'b1, N_OUT, 1'b0, 1'b0);

    // Abort while issuing pixel 300.
    start_frame(0, N_OUT, 0, 1'b0);
    for (c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (o_rd_en && o_rd_addr == 10'd300) break;
    end
    check("abort_at", o_rd_addr, 300);
    i_abort = 1'b1;
    core_en = 1'b0;
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    check("abort_rd_en", o_rd_en, 0);
    check("abort_core_valid", o_core_valid, 0);
    check("abort_wr_en", o_wr_en, 0);
    check("abort_busy", o_busy, 0);
    rd_q.delete();
    wr_q.delete();
    repeat (5) @(negedge clk);
    check("abort_no_done", done_seen, 0);
    check("abort_idle_rd_en", o_rd_en, 0);

    // Restart from address 0, with a simultaneous abort that start must override.
    run_frame(100, N_OUT, 0, 1'b0, N_OUT, 1'b0, 1'b1);

    // Reset asserted while issuing pixel 100.
    start_frame(0, N_OUT, 3, 1'b0);
    for (c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (o_rd_en && o_rd_addr == 10'd100) break;
    end
    check("rst_at", o_rd_addr, 100);
    reset_n = 1'b0;
    core_en = 1'b0;
    #1;
    check("mrst_busy", o_busy, 0);
    check("mrst_rd_en", o_rd_en, 0);
    check("mrst_rd_addr", o_rd_addr, 0);
    check("mrst_core_valid", o_core_valid, 0);
    check("mrst_core_fmap", o_core_fmap, 0);
    check("mrst_wr_en", o_wr_en, 0);
    check("mrst_wr_addr", o_wr_addr, 0);
    check("mrst_wr_data", o_wr_data, 0);
    check("mrst_done", o_done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd_q.delete();
    wr_q.delete();
    repeat (6) @(negedge clk);
    check("mrst_no_done", done_seen, 0);
    check("mrst_idle_busy", o_busy, 0);
    check("mrst_idle_rd_en", o_rd_en, 0);

    // Frame after reset runs normally.
    run_frame(0, N_OUT, 0, 1'b0, N_OUT, 1'b0, 1'b0);

`ifdef CNN_FRAME_CTRL_TIMEOUT_EN
    // Core stalls after 500 outputs; done must follow TO_CYC cycles after the last one.
    run_frame(400, 500, 0, 1'b0, 500, 1'b1, 1'b0);
    check("timeout_latency", done_cyc - last_valid_edge, TO_CYC);
    check("err_sticky", o_err, 1);
    run_frame(0, N_OUT, 0, 1'b0, N_OUT, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
